reset_sequencer: RTL and testbench

//  Parametrised power-on and forced-reset sequencer; next generation of the CPC2 global reset.

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer_sync.sv | 24 ++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the FSM state encoding and width helper functions.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2,
        ST_FORCE = 2'd3
    } state_t;

    // Bits needed to hold the value v (at least 1).
    function automatic int width_of(input int v);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(v)) w++;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Supervisor-facing bundle of the reset sequencer.
// forced_reset_i in; n_reset_o, busy_o, stage_o out.
interface reset_sequencer_if #(
    parameter int CHANNELS = 3
);
    import reset_seq_pkg::*;

    localparam int SW = width_of(CHANNELS);

    logic                forced_reset_i;
    logic [CHANNELS-1:0] n_reset_o;
    logic                busy_o;
    logic [SW-1:0]       stage_o;

    modport master (
        input  forced_reset_i,
        output n_reset_o,
        output busy_o,
        output stage_o
    );

    modport slave (
        output forced_reset_i,
        input  n_reset_o,
        input  busy_o,
        input  stage_o
    );

endinterface

// File: rtl/reset_sequencer_sync.sv
// Multi-flop synchroniser for one asynchronous level.
// Ports: clock_i, reset_i (async, clears flops), d_i, q_o.
module bit_synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / forced reset sequencer releasing channels in order.
// Ports: clock_i, reset_i (async high), bus (forced_reset_i, n_reset_o, busy_o, stage_o).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int          CHANNELS         = 3,
    parameter int          POR_CYCLES       = 255,
    parameter int          STAGE_CYCLES     = 16,
    parameter logic [31:0] FORCE_MASK       = 32'b101,
    parameter int          FORCE_MIN_CYCLES = 8,
    parameter int          SYNC_STAGES      = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    reset_sequencer_if.master bus
);

    localparam int CW = width_of(
        max3(POR_CYCLES, STAGE_CYCLES, FORCE_MIN_CYCLES));
    localparam int SW = width_of(CHANNELS);

    localparam logic [CHANNELS-1:0] MASK = FORCE_MASK[CHANNELS-1:0];

    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STG_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0] MIN_LAST =
        (FORCE_MIN_CYCLES > 0) ? CW'(FORCE_MIN_CYCLES - 1) : '0;
    localparam logic [SW-1:0] CH_LAST = SW'(CHANNELS - 1);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("reset_sequencer: CHANNELS must be 1..32");
    end
    if (POR_CYCLES < 1) begin : g_bad_por
        $error("reset_sequencer: POR_CYCLES must be >= 1");
    end
    if (STAGE_CYCLES < 1) begin : g_bad_stage
        $error("reset_sequencer: STAGE_CYCLES must be >= 1");
    end
    if (FORCE_MIN_CYCLES < 0) begin : g_bad_min
        $error("reset_sequencer: FORCE_MIN_CYCLES must be >= 0");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if ((FORCE_MASK >> CHANNELS) != 32'd0) begin : g_bad_mask
        $error("reset_sequencer: FORCE_MASK wider than CHANNELS");
    end

    logic                force_s;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       s_q, s_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic [CHANNELS-1:0] n_reset_d;

    bit_synchroniser #(
        .STAGES (SYNC_STAGES)
    ) u_force_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (bus.forced_reset_i),
        .q_o     (force_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        unique case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) begin
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = force_s ? ST_FORCE : ST_STAGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STAGE: begin
                if (force_s) begin
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = ST_FORCE;
                end else if (cnt_q == STG_LAST) begin
                    cnt_d = '0;
                    s_d   = s_q + 1'b1;
                    if (s_q == CH_LAST) state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (force_s) begin
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                s_d = '0;
                // Any high sample of the force restarts the hold.
                if (force_s) begin
                    cnt_d = '0;
                end else if (FORCE_MIN_CYCLES == 0 || cnt_q == MIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STAGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                s_d     = '0;
                state_d = ST_POR;
            end
        endcase
    end

    // Unmasked channels latch high once released and ignore the force.
    always_comb begin
        sticky_d  = sticky_q;
        n_reset_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!MASK[i] && int'(s_d) > i) sticky_d[i] = 1'b1;
            n_reset_d[i] = MASK[i]
                ? (int'(s_d) > i && state_d != ST_FORCE)
                : sticky_d[i];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_POR;
            cnt_q         <= '0;
            s_q           <= '0;
            sticky_q      <= '0;
            bus.n_reset_o <= '0;
            bus.busy_o    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s_q           <= s_d;
            sticky_q      <= sticky_d;
            bus.n_reset_o <= n_reset_d;
            bus.busy_o    <= (state_d != ST_RUN);
        end
    end

    assign bus.stage_o = s_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (3 channels, POR 10, stage 4).
// Expected output changes are queued with their cycle; a monitor checks them.
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  q[$];

    reset_sequencer_if #(.CHANNELS(3)) bus ();

    reset_sequencer #(
        .CHANNELS         (3),
        .POR_CYCLES       (10),
        .STAGE_CYCLES     (4),
        .FORCE_MASK       (32'b101),
        .FORCE_MIN_CYCLES (8),
        .SYNC_STAGES      (2)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [5:0] outs();
        return {bus.n_reset_o, bus.busy_o, bus.stage_o};
    endfunction

    task automatic exp_ev(input int c, input logic [2:0] n,
                          input logic b, input logic [1:0] st);
        ev_t e;
        e.cyc = c;
        e.val = {n, b, st};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the outputs must match the queue head.
    initial begin
        logic [5:0] prev, cur;
        ev_t        e;
        @(negedge clk);
        chk("reset_state", outs(), 6'b000_1_00);
        prev = outs();
        forever begin
            @(negedge clk);
            cur = outs();
            if (cur !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: cyc %0d got %b want none",
                             cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        n_bad++;
                        $display("FAIL event: got cyc %0d val %b want cyc %0d val %b",
                                 cyc, cur, e.cyc, e.val);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.forced_reset_i = 1'b0;

        // Power-on sequence.
        goto(2);
        rst = 1'b0;
        exp_ev(16, 3'b001, 1'b1, 2'd1);
        exp_ev(20, 3'b011, 1'b1, 2'd2);
        exp_ev(24, 3'b111, 1'b0, 2'd3);

        // Force in RUN for 20 cycles.
        goto(40);
        bus.forced_reset_i = 1'b1;
        exp_ev(43, 3'b010, 1'b1, 2'd0);
        goto(60);
        bus.forced_reset_i = 1'b0;
        exp_ev(74, 3'b011, 1'b1, 2'd1);
        exp_ev(78, 3'b011, 1'b1, 2'd2);
        exp_ev(82, 3'b111, 1'b0, 2'd3);

        // Force re-pulsed during the minimum hold.
        goto(100);
        bus.forced_reset_i = 1'b1;
        exp_ev(103, 3'b010, 1'b1, 2'd0);
        goto(105);
        bus.forced_reset_i = 1'b0;
        goto(109);
        bus.forced_reset_i = 1'b1;
        goto(112);
        bus.forced_reset_i = 1'b0;
        exp_ev(126, 3'b011, 1'b1, 2'd1);
        exp_ev(130, 3'b011, 1'b1, 2'd2);
        exp_ev(134, 3'b111, 1'b0, 2'd3);

        // Reset from RUN with force held across POR.
        goto(150);
        rst = 1'b1;
        bus.forced_reset_i = 1'b1;
        exp_ev(150, 3'b000, 1'b1, 2'd0);
        #1;
        chk("async_reset_run", outs(), 6'b000_1_00);
        goto(151);
        rst = 1'b0;
        goto(180);
        bus.forced_reset_i = 1'b0;
        exp_ev(194, 3'b001, 1'b1, 2'd1);
        exp_ev(198, 3'b011, 1'b1, 2'd2);
        exp_ev(202, 3'b111, 1'b0, 2'd3);

        // Reset mid-STAGE with s=1.
        goto(220);
        rst = 1'b1;
        exp_ev(220, 3'b000, 1'b1, 2'd0);
        goto(221);
        rst = 1'b0;
        exp_ev(235, 3'b001, 1'b1, 2'd1);
        goto(237);
        rst = 1'b1;
        exp_ev(237, 3'b000, 1'b1, 2'd0);
        #1;
        chk("async_reset_stage", outs(), 6'b000_1_00);
        goto(238);
        rst = 1'b0;
        exp_ev(252, 3'b001, 1'b1, 2'd1);
        exp_ev(256, 3'b011, 1'b1, 2'd2);
        exp_ev(260, 3'b111, 1'b0, 2'd3);

        // One-cycle force glitch.
        goto(280);
        bus.forced_reset_i = 1'b1;
        goto(281);
        bus.forced_reset_i = 1'b0;
        exp_ev(283, 3'b010, 1'b1, 2'd0);
        exp_ev(295, 3'b011, 1'b1, 2'd1);
        exp_ev(299, 3'b011, 1'b1, 2'd2);
        exp_ev(303, 3'b111, 1'b0, 2'd3);

        goto(330);
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        while (q.size() != 0) begin
            ev_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got none want cyc %0d val %b",
                     e.cyc, e.val);
        end
        @(negedge clk);
        chk("final_run", outs(), 6'b111_0_11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
